window_scroll_ctrl: RTL and testbench
=====================================

# window_scroll_ctrl

Turns the two raw scroll push-buttons into clean one-cycle step commands for the 3-of-5 digit window selector in the signed-multiplier display path. It synchronizes, debounces and edge-detects each button, adds hold-to-repeat, and blocks steps beyond the window limits. It also keeps a mirror of the selector's current offset. Its outputs drive the selector's step inputs directly: `shift_down` to w1 and `shift_up` to w2.

## Interface

- `DB_CYCLES`, 500000: consecutive stable cycles required before a debounced level changes (5 ms at 100 MHz).
- `REPEAT_DELAY`, 50000000: cycles from the first step of a held press to the first repeat step.
- `REPEAT_RATE`, 20000000: cycles between later repeat steps.
- `MAX_OFFSET`, 2: highest window offset.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `btn_left` in 1: raw, asynchronous button; requests offset − 1.
- `btn_right` in 1: raw, asynchronous button; requests offset + 1.
- `en` in 1: when low, no steps are issued.
- `shift_down` out 1: one-cycle step-down pulse (selector w1).
- `shift_up` out 1: one-cycle step-up pulse (selector w2).
- `offset` out 2: mirror of the selector offset, range 0..MAX_OFFSET.
- `at_min` out 1: high when offset == 0.
- `at_max` out 1: high when offset == MAX_OFFSET.

## Operation

- **Synchronizer.** Each button passes through a 2-flop synchronizer.
- **Debounce.** Each button has its own counter.
  - The counter increments while the synced level differs from the debounced level.
  - It clears to 0 when the levels match.
  - When the count reaches DB_CYCLES, the debounced level flips and the counter clears.
- **FSM states.** IDLE, FIRST, DELAY, REPEAT, LOCK.
- **IDLE.**
  - Goes to LOCK if both debounced levels are high.
  - Otherwise, on a debounced rising edge of exactly one button: latch its direction and go to FIRST.
- **FIRST.** Issues one step and loads the timer with REPEAT_DELAY−1, then goes to DELAY.
- **DELAY and REPEAT.**
  - The timer counts down each cycle.
  - At 0 a step is issued, the timer reloads with REPEAT_RATE−1, and the state is REPEAT.
  - Releasing the latched button returns to IDLE.
  - If the other button becomes high, go to LOCK.
- **LOCK.** Issues no steps. Returns to IDLE only when both debounced levels are low.
- **Step issue.**
  - A step asserts `shift_up` or `shift_down` for exactly one cycle.
  - The pulse is suppressed when it would move past a limit: no `shift_down` at offset 0, no `shift_up` at MAX_OFFSET.
  - The FSM sequence continues even when a pulse is suppressed.
- **Offset mirror.**
  - On the clock edge where `shift_up` is high, offset increments.
  - On the clock edge where `shift_down` is high, offset decrements.
  - `shift_up` and `shift_down` are never high in the same cycle.
- **`en` low.** Forces the FSM to IDLE with both pulses low. Offset is held. Debounce keeps running. A button already held when `en` rises does not step until it is released and pressed again.
- **Reset.** Asynchronous; state after reset:
  - FSM in IDLE, all counters 0, synchronizer flops 0, debounced levels 0.
  - `offset` = 0, `at_min` = 1, `at_max` = 0.
  - `shift_up` = 0, `shift_down` = 0.

## Timing

- All outputs are registered.
- A raw edge reaches the debounced level after 2 cycles of synchronizer plus DB_CYCLES stable cycles.
- The first step pulse occurs 2 cycles after the debounced rising edge (IDLE→FIRST, then a registered pulse).
- `offset`, `at_min` and `at_max` change on the cycle after the pulse. This matches when the selector's own register updates.
- Hold-to-repeat:
  - The first repeat pulse comes REPEAT_DELAY cycles after the first pulse.
  - Each later repeat pulse comes REPEAT_RATE cycles after the previous one.
- Release during DELAY or REPEAT: no further pulses once the debounced level falls. A pulse already registered on that cycle still completes.
- Reset mid-press: outputs go to their reset values immediately. A button still held after reset release must be released and pressed again to step.

## Test plan

All scenarios use DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8, MAX_OFFSET=2.

- **Bounce rejection.** Toggle `btn_right` every 2 cycles for 20 cycles, then hold it → exactly one `shift_up`, 8 cycles after the stable hold begins; offset goes 0→1.
- **Hold repeat and limit.** Hold `btn_right` 60 cycles from offset 0 → pulses at t0 and t0+20; the t0+28 and t0+36 steps are suppressed; offset ends at 2 and `at_max`=1.
- **Lower limit.** At offset 0, press `btn_left` → no `shift_down`; offset stays 0 and `at_min` stays 1.
- **Simultaneous press.** While `btn_left` is held in DELAY, press `btn_right` → no pulses until both are released. A fresh `btn_left` press afterwards gives one `shift_down`.
- **Enable gating.** Hold `btn_right` with `en`=0, then raise `en` → no pulse. Release, then press again → one `shift_up`.
- **Reset mid-press.** Assert `rst` in REPEAT at offset 1 → offset=0, `at_min`=1, both pulses 0 within the same cycle. No pulse after `rst` releases while the button is still held.

Source files
------------

// File: rtl/window_scroll_ctrl_if.sv
// Scroll-button request and step-command bundle between the button front end
// and the 3-of-5 digit window selector.
interface window_scroll_ctrl_if;
  logic       btn_left;
  logic       btn_right;
  logic       en;
  logic       shift_down;
  logic       shift_up;
  logic [1:0] offset;
  logic       at_min;
  logic       at_max;

  modport master (
    output btn_left, btn_right, en,
    input  shift_down, shift_up, offset, at_min, at_max
  );

  modport slave (
    input  btn_left, btn_right, en,
    output shift_down, shift_up, offset, at_min, at_max
  );
endinterface

// File: rtl/window_scroll_ctrl.sv
// Cleans the two scroll push-buttons into limit-checked one-cycle step pulses
// with hold-to-repeat, and mirrors the digit window selector's offset.
module window_scroll_ctrl #(
  parameter int unsigned DB_CYCLES    = 500000,
  parameter int unsigned REPEAT_DELAY = 50000000,
  parameter int unsigned REPEAT_RATE  = 20000000,
  parameter int unsigned MAX_OFFSET   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  window_scroll_ctrl_if.slave  scroll
);

  localparam int unsigned DBW  = $clog2(DB_CYCLES + 1);
  localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
  localparam logic [TW-1:0]  RD_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0]  RR_LAST  = TW'(REPEAT_RATE - 1);
  localparam logic [1:0]     OFF_MAX  = 2'(MAX_OFFSET);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FIRST  = 3'd1;
  localparam logic [2:0] S_DELAY  = 3'd2;
  localparam logic [2:0] S_REPEAT = 3'd3;
  localparam logic [2:0] S_LOCK   = 3'd4;

  // Bit 0 is the left (down) button, bit 1 the right (up) button.
  logic [1:0]     btn;
  logic [1:0]     s1, s2, db, dbp, arm, rise;
  logic [1:0]     warm;
  logic [DBW-1:0] cnt [2];

  logic [2:0]     state, state_d;
  logic [TW-1:0]  timer, timer_d;
  logic           dir_up, dir_d;
  logic           step, held, other;

  logic           up_q, down_q, up_d, down_d;
  logic [1:0]     off_q, off_eff;
  logic           at_min_q, at_max_q;

  assign btn = {scroll.btn_right, scroll.btn_left};

  // A button held through reset must be seen released before it may step:
  // arm only once the synchronizer has refilled and shows the button low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      dbp  <= '0;
      arm  <= '0;
      warm <= '0;
      for (int unsigned i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      dbp  <= db;
      warm <= {warm[0], 1'b1};
      arm  <= arm | ({2{warm[1]}} & ~s2 & ~db);
      for (int unsigned i = 0; i < 2; i++) begin
        if (s2[i] != db[i]) begin
          if (cnt[i] == DB_LAST) begin
            db[i]  <= s2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign rise  = db & ~dbp & arm;
  assign held  = dir_up ? db[1] : db[0];
  assign other = dir_up ? db[0] : db[1];

  always_comb begin
    state_d = state;
    timer_d = timer;
    dir_d   = dir_up;
    step    = 1'b0;
    if (!scroll.en) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (&db) begin
            state_d = S_LOCK;
          end else if (^rise) begin
            dir_d   = rise[1];
            state_d = S_FIRST;
          end
        end
        S_FIRST: begin
          step    = 1'b1;
          timer_d = RD_LAST;
          state_d = S_DELAY;
        end
        S_DELAY, S_REPEAT: begin
          if (!held) begin
            state_d = S_IDLE;
          end else if (other) begin
            state_d = S_LOCK;
          end else if (timer == '0) begin
            step    = 1'b1;
            timer_d = RR_LAST;
            state_d = S_REPEAT;
          end else begin
            timer_d = timer - 1'b1;
          end
        end
        S_LOCK: begin
          if (db == '0) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Limit checks use the offset as it will be after this edge, so a pulse
  // still in flight is already accounted for.
  always_comb begin
    off_eff = off_q;
    if (up_q)        off_eff = off_q + 2'd1;
    else if (down_q) off_eff = off_q - 2'd1;
  end

  assign up_d   = step &  dir_up & (off_eff != OFF_MAX);
  assign down_d = step & ~dir_up & (off_eff != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      timer    <= '0;
      dir_up   <= 1'b0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      off_q    <= '0;
      at_min_q <= 1'b1;
      at_max_q <= 1'b0;
    end else begin
      state    <= state_d;
      timer    <= timer_d;
      dir_up   <= dir_d;
      up_q     <= up_d;
      down_q   <= down_d;
      off_q    <= off_eff;
      at_min_q <= (off_eff == 2'd0);
      at_max_q <= (off_eff == OFF_MAX);
    end
  end

  assign scroll.shift_up   = up_q;
  assign scroll.shift_down = down_q;
  assign scroll.offset     = off_q;
  assign scroll.at_min     = at_min_q;
  assign scroll.at_max     = at_max_q;

endmodule

// File: tb/tb_window_scroll_ctrl.sv
// Directed bench for window_scroll_ctrl with short debounce/repeat timing.
module tb_window_scroll_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   overlap = 0;
  int   a;
  int   up_q[$];
  int   dn_q[$];

  window_scroll_ctrl_if sif ();

  window_scroll_ctrl #(
    .DB_CYCLES   (4),
    .REPEAT_DELAY(20),
    .REPEAT_RATE (8),
    .MAX_OFFSET  (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .scroll(sif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse log: the edge index at which each pulse was registered.
  always @(negedge clk) begin
    if (sif.shift_up)   up_q.push_back(cyc);
    if (sif.shift_down) dn_q.push_back(cyc);
    if (sif.shift_up && sif.shift_down) overlap++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_log;
    up_q.delete();
    dn_q.delete();
  endtask

  function automatic int first_of(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  function automatic int second_of(input int q[$]);
    return (q.size() > 1) ? q[1] : -1;
  endfunction

  initial begin
    rst           = 1'b1;
    sif.btn_left  = 1'b0;
    sif.btn_right = 1'b0;
    sif.en        = 1'b1;
    wait_cyc(3);
    chk("rst_offset", int'(sif.offset), 0);
    chk("rst_at_min", int'(sif.at_min), 1);
    chk("rst_at_max", int'(sif.at_max), 0);
    chk("rst_up",     int'(sif.shift_up), 0);
    chk("rst_down",   int'(sif.shift_down), 0);
    rst = 1'b0;
    wait_cyc(6);

    // Lower limit: left at offset 0 never pulses, through the first repeat.
    clear_log();
    sif.btn_left = 1'b1;
    wait_cyc(30);
    chk("lo_down_cnt", dn_q.size(), 0);
    chk("lo_offset",   int'(sif.offset), 0);
    chk("lo_at_min",   int'(sif.at_min), 1);
    sif.btn_left = 1'b0;
    wait_cyc(10);

    // Bounce rejection: 2-cycle bursts never settle; steady hold steps at a+8.
    clear_log();
    for (int i = 0; i < 10; i++) begin
      sif.btn_right = (i % 2 == 0);
      wait_cyc(2);
    end
    a = cyc;
    sif.btn_right = 1'b1;
    wait_cyc(12);
    chk("bnc_up_cnt", up_q.size(), 1);
    chk("bnc_up_t",   first_of(up_q), a + 8);
    chk("bnc_offset", int'(sif.offset), 1);
    chk("bnc_at_min", int'(sif.at_min), 0);
    sif.btn_right = 1'b0;
    wait_cyc(10);

    // Single left press back to 0.
    clear_log();
    a = cyc;
    sif.btn_left = 1'b1;
    wait_cyc(12);
    chk("dn1_cnt",    dn_q.size(), 1);
    chk("dn1_t",      first_of(dn_q), a + 8);
    chk("dn1_offset", int'(sif.offset), 0);
    chk("dn1_at_min", int'(sif.at_min), 1);
    sif.btn_left = 1'b0;
    wait_cyc(10);

    // Hold repeat: steps at a+8 and a+28; a+36.. are suppressed at the limit.
    clear_log();
    a = cyc;
    sif.btn_right = 1'b1;
    wait_cyc(60);
    chk("rep_up_cnt", up_q.size(), 2);
    chk("rep_up_t0",  first_of(up_q), a + 8);
    chk("rep_up_t1",  second_of(up_q), a + 28);
    chk("rep_offset", int'(sif.offset), 2);
    chk("rep_at_max", int'(sif.at_max), 1);
    sif.btn_right = 1'b0;
    wait_cyc(10);

    // Simultaneous press: right joins while left is in DELAY -> locked out.
    clear_log();
    a = cyc;
    sif.btn_left = 1'b1;
    wait_cyc(12);
    sif.btn_right = 1'b1;
    wait_cyc(30);
    sif.btn_left  = 1'b0;
    sif.btn_right = 1'b0;
    wait_cyc(10);
    chk("lck_down_cnt", dn_q.size(), 1);
    chk("lck_down_t",   first_of(dn_q), a + 8);
    chk("lck_up_cnt",   up_q.size(), 0);
    chk("lck_offset",   int'(sif.offset), 1);
    clear_log();
    a = cyc;
    sif.btn_left = 1'b1;
    wait_cyc(12);
    chk("lck_fresh_cnt", dn_q.size(), 1);
    chk("lck_fresh_t",   first_of(dn_q), a + 8);
    chk("lck_offset2",   int'(sif.offset), 0);
    sif.btn_left = 1'b0;
    wait_cyc(10);

    // Enable gating: press held across en rising does not step.
    clear_log();
    sif.en = 1'b0;
    sif.btn_right = 1'b1;
    wait_cyc(12);
    sif.en = 1'b1;
    wait_cyc(20);
    chk("en_up_cnt", up_q.size(), 0);
    chk("en_offset", int'(sif.offset), 0);
    sif.btn_right = 1'b0;
    wait_cyc(10);
    clear_log();
    a = cyc;
    sif.btn_right = 1'b1;
    wait_cyc(12);
    chk("en_fresh_cnt", up_q.size(), 1);
    chk("en_fresh_t",   first_of(up_q), a + 8);
    chk("en_offset2",   int'(sif.offset), 1);

    // Reset mid-press, on the cycle the a+28 repeat pulse is out at offset 1.
    wait_cyc(16);
    chk("mr_pre_up",     int'(sif.shift_up), 1);
    chk("mr_pre_offset", int'(sif.offset), 1);
    rst = 1'b1;
    #1;
    chk("mr_up",     int'(sif.shift_up), 0);
    chk("mr_down",   int'(sif.shift_down), 0);
    chk("mr_offset", int'(sif.offset), 0);
    chk("mr_at_min", int'(sif.at_min), 1);
    chk("mr_at_max", int'(sif.at_max), 0);
    wait_cyc(3);
    rst = 1'b0;
    clear_log();
    wait_cyc(40);
    chk("mr_post_up_cnt", up_q.size(), 0);
    chk("mr_post_offset", int'(sif.offset), 0);
    sif.btn_right = 1'b0;
    wait_cyc(10);

    chk("no_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
